// File: rtl/led_pwm_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : led_pwm_ctrl_if
// Description : AXI4-Lite register-bus bundle used by led_pwm_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface led_pwm_ctrl_if #(
    parameter int ADDR_WIDTH = 7
);
    logic [ADDR_WIDTH-1:0] S_AXI_AWADDR;
    logic                  S_AXI_AWVALID;
    logic                  S_AXI_AWREADY;
    logic [31:0]           S_AXI_WDATA;
    logic [3:0]            S_AXI_WSTRB;
    logic                  S_AXI_WVALID;
    logic                  S_AXI_WREADY;
    logic [1:0]            S_AXI_BRESP;
    logic                  S_AXI_BVALID;
    logic                  S_AXI_BREADY;
    logic [ADDR_WIDTH-1:0] S_AXI_ARADDR;
    logic                  S_AXI_ARVALID;
    logic                  S_AXI_ARREADY;
    logic [31:0]           S_AXI_RDATA;
    logic [1:0]            S_AXI_RRESP;
    logic                  S_AXI_RVALID;
    logic                  S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface
`default_nettype wire

// File: rtl/led_pwm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : led_pwm_ctrl
// Description : AXI4-Lite controlled multi-channel LED driver (off/on/PWM/blink).
//               Define LED_PWM_CTRL_BLINK_EN to enable MODE 3 blink.
// Revision    : 1.0 - initial release
// ============================================================================
module led_pwm_ctrl #(
    parameter int NUM_LEDS           = 4,
    parameter int PWM_WIDTH          = 8,
    parameter int C_S_AXI_ADDR_WIDTH = 7
) (
    input  logic                ACLK,
    input  logic                ARESET,
    led_pwm_ctrl_if.slave       s_axi,
    output logic [NUM_LEDS-1:0] led_out
);
    localparam int         c_IDX_W       = C_S_AXI_ADDR_WIDTH - 2;
    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    logic                 r_en;
    logic [15:0]          r_prescale;
    logic [PWM_WIDTH-1:0] r_duty [NUM_LEDS];
    logic [1:0]           r_mode [NUM_LEDS];

    logic [15:0]          r_presc_cnt;
    logic [PWM_WIDTH-1:0] r_pwm_cnt;

    logic                 r_awready;
    logic                 r_bvalid;
    logic [1:0]           r_bresp;
    logic                 r_arready;
    logic                 r_rvalid;
    logic [1:0]           r_rresp;
    logic [31:0]          r_rdata;

    logic [c_IDX_W-1:0]   w_wr_idx;
    logic [c_IDX_W-1:0]   w_rd_idx;
    logic                 w_wr_ok;
    logic                 w_rd_ok;
    logic                 w_wr_hs;
    logic                 w_rd_hs;
    logic [31:0]          w_wr_mask;
    logic [31:0]          w_wr_merged;
    logic [31:0]          w_rd_val;
    logic                 w_tick;
    logic [NUM_LEDS-1:0]  w_led_next;
    logic                 w_unused;

    // Word-aligned decode; the byte offset within a word is ignored.
    function automatic logic idx_mapped(input logic [c_IDX_W-1:0] idx);
        int idx_v;
        idx_v = int'(idx);
        return (idx_v <= 2) || ((idx_v >= 4) && ((idx_v - 4) < NUM_LEDS));
    endfunction

    function automatic logic [31:0] reg_value(input logic [c_IDX_W-1:0] idx);
        logic [31:0] v;
        int          idx_v;
        v     = '0;
        idx_v = int'(idx);
        if (idx_v == 0) begin
            v[0] = r_en;
        end else if (idx_v == 1) begin
            v[15:0] = r_prescale;
        end else if (idx_v == 2) begin
            v[NUM_LEDS-1:0] = led_out;
        end else begin
            for (int ch = 0; ch < NUM_LEDS; ch++) begin
                if (idx_v == ch + 4) begin
                    v[PWM_WIDTH-1:0] = r_duty[ch];
                    v[17:16]         = r_mode[ch];
                end
            end
        end
        return v;
    endfunction

    function automatic logic led_next(
        input logic                 en,
        input logic [1:0]           mode,
        input logic [PWM_WIDTH-1:0] duty,
        input logic [PWM_WIDTH-1:0] cnt
    );
        logic v;
        v = 1'b0;
        if (en) begin
            case (mode)
                2'd1:    v = 1'b1;
                2'd2:    v = (duty > cnt);
`ifdef LED_PWM_CTRL_BLINK_EN
                2'd3:    v = ~cnt[PWM_WIDTH-1];
`else
                2'd3:    v = 1'b0;
`endif
                default: v = 1'b0;
            endcase
        end
        return v;
    endfunction

    assign w_wr_idx = s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_rd_idx = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_wr_ok  = idx_mapped(w_wr_idx);
    assign w_rd_ok  = idx_mapped(w_rd_idx);
    assign w_wr_hs  = r_awready && s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID;
    assign w_rd_hs  = r_arready && s_axi.S_AXI_ARVALID;
    assign w_unused = ^{s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

    assign w_wr_mask = {{8{s_axi.S_AXI_WSTRB[3]}}, {8{s_axi.S_AXI_WSTRB[2]}},
                        {8{s_axi.S_AXI_WSTRB[1]}}, {8{s_axi.S_AXI_WSTRB[0]}}};
    // Read-modify-write against the current value so unstrobed lanes survive.
    assign w_wr_merged = (reg_value(w_wr_idx) & ~w_wr_mask) | (s_axi.S_AXI_WDATA & w_wr_mask);
    assign w_rd_val    = reg_value(w_rd_idx);

    assign s_axi.S_AXI_AWREADY = r_awready;
    assign s_axi.S_AXI_WREADY  = r_awready;
    assign s_axi.S_AXI_BVALID  = r_bvalid;
    assign s_axi.S_AXI_BRESP   = r_bresp;
    assign s_axi.S_AXI_ARREADY = r_arready;
    assign s_axi.S_AXI_RVALID  = r_rvalid;
    assign s_axi.S_AXI_RRESP   = r_rresp;
    assign s_axi.S_AXI_RDATA   = r_rdata;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_awready  <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= c_RESP_OKAY;
            r_en       <= 1'b0;
            r_prescale <= '0;
            for (int ch = 0; ch < NUM_LEDS; ch++) begin
                r_duty[ch] <= '0;
                r_mode[ch] <= '0;
            end
        end else begin
            r_awready <= 1'b0;
            if (w_wr_hs) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_ok ? c_RESP_OKAY : c_RESP_SLVERR;
                if (w_wr_ok) begin
                    if (int'(w_wr_idx) == 0) begin
                        r_en <= w_wr_merged[0];
                    end
                    if (int'(w_wr_idx) == 1) begin
                        r_prescale <= w_wr_merged[15:0];
                    end
                    for (int ch = 0; ch < NUM_LEDS; ch++) begin
                        if (int'(w_wr_idx) == ch + 4) begin
                            r_duty[ch] <= w_wr_merged[PWM_WIDTH-1:0];
                            r_mode[ch] <= w_wr_merged[17:16];
                        end
                    end
                end
            end else if (r_bvalid && s_axi.S_AXI_BREADY) begin
                r_bvalid <= 1'b0;
            end else if (!r_bvalid && !r_awready && s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID) begin
                r_awready <= 1'b1;
            end
        end
    end

    // Register values are sampled before any same-edge write lands.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= c_RESP_OKAY;
            r_rdata   <= '0;
        end else begin
            r_arready <= 1'b0;
            if (w_rd_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_ok ? w_rd_val : 32'd0;
                r_rresp  <= w_rd_ok ? c_RESP_OKAY : c_RESP_SLVERR;
            end else if (r_rvalid && s_axi.S_AXI_RREADY) begin
                r_rvalid <= 1'b0;
            end else if (!r_rvalid && !r_arready && s_axi.S_AXI_ARVALID) begin
                r_arready <= 1'b1;
            end
        end
    end

    // ">=" lets a lowered PRESCALE pull an overshooting counter back at once.
    assign w_tick = r_en && (r_presc_cnt >= r_prescale);

    always_ff @(posedge ACLK) begin
        if (ARESET || !r_en) begin
            r_presc_cnt <= '0;
            r_pwm_cnt   <= '0;
        end else if (w_tick) begin
            r_presc_cnt <= '0;
            r_pwm_cnt   <= r_pwm_cnt + PWM_WIDTH'(1);
        end else begin
            r_presc_cnt <= r_presc_cnt + 16'd1;
        end
    end

    for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_led
        assign w_led_next[gi] = led_next(r_en, r_mode[gi], r_duty[gi], r_pwm_cnt);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            led_out <= '0;
        end else begin
            led_out <= w_led_next;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_led_pwm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_pwm_ctrl
// Description : Directed self-checking bench for led_pwm_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pwm_ctrl;
    localparam int NUM_LEDS  = 4;
    localparam int PWM_WIDTH = 8;
    localparam int AW        = 7;

    logic                clk = 1'b0;
    logic                rst;
    logic [NUM_LEDS-1:0] led_out;
    int                  n_checks = 0;
    int                  n_fail   = 0;

    always #5 clk = ~clk;

    led_pwm_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    led_pwm_ctrl #(
        .NUM_LEDS          (NUM_LEDS),
        .PWM_WIDTH         (PWM_WIDTH),
        .C_S_AXI_ADDR_WIDTH(AW)
    ) dut (
        .ACLK   (clk),
        .ARESET (rst),
        .s_axi  (bus),
        .led_out(led_out)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int n;
        @(negedge clk);
        bus.S_AXI_AWADDR  = addr;
        bus.S_AXI_WDATA   = data;
        bus.S_AXI_WSTRB   = strb;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WVALID  = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.S_AXI_AWREADY && n < 20);
        check_value("aw_handshake", {31'd0, bus.S_AXI_AWREADY & bus.S_AXI_WREADY}, 32'd1);
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        n = 0;
        while (!bus.S_AXI_BVALID && n < 20) begin @(negedge clk); n++; end
        resp = bus.S_AXI_BVALID ? bus.S_AXI_BRESP : 2'b11;
        bus.S_AXI_BREADY = 1'b1;
        @(negedge clk);
        bus.S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        @(negedge clk);
        bus.S_AXI_ARADDR  = addr;
        bus.S_AXI_ARVALID = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.S_AXI_ARREADY && n < 20);
        check_value("ar_handshake", {31'd0, bus.S_AXI_ARREADY}, 32'd1);
        @(negedge clk);
        bus.S_AXI_ARVALID = 1'b0;
        n = 0;
        while (!bus.S_AXI_RVALID && n < 20) begin @(negedge clk); n++; end
        data = bus.S_AXI_RVALID ? bus.S_AXI_RDATA : 32'hDEAD_BEEF;
        resp = bus.S_AXI_RVALID ? bus.S_AXI_RRESP : 2'b11;
        bus.S_AXI_RREADY = 1'b1;
        @(negedge clk);
        bus.S_AXI_RREADY = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic write_ok(input string tag, input logic [AW-1:0] addr, input logic [31:0] data);
        logic [1:0] r;
        axi_write(addr, data, 4'hF, r);
        check_value(tag, {30'd0, r}, 32'd0);
    endtask

    task automatic read_expect(input string tag, input logic [AW-1:0] addr,
                               input logic [31:0] exp, input logic [1:0] exp_resp);
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(addr, d, r);
        check_value(tag, d, exp);
        check_value({tag, "_resp"}, {30'd0, r}, {30'd0, exp_resp});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;
        int          highs, s63, s64, n, period;
        logic        prev, busy_seen, bv_dropped;

        rst = 1'b1;
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA = '0;  bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b0;
        repeat (3) @(negedge clk);
        check_value("reset_outputs",
                    {26'd0, led_out, bus.S_AXI_AWREADY, bus.S_AXI_WREADY},
                    32'd0);
        check_value("reset_valids",
                    {29'd0, bus.S_AXI_ARREADY, bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 32'd0);
        rst = 1'b0;

        // Write/readback of the on/off map
        write_ok("wr_ch0", 7'h10, 32'h0001_0000);
        write_ok("wr_ch1", 7'h14, 32'h0000_0000);
        write_ok("wr_ch2", 7'h18, 32'h0001_0000);
        write_ok("wr_ch3", 7'h1C, 32'h0001_0000);
        write_ok("wr_ctrl", 7'h00, 32'h0000_0001);
        repeat (2) @(negedge clk);
        check_value("led_onoff", {28'd0, led_out}, 32'hD);
        read_expect("rd_status", 7'h08, 32'hD, 2'b00);
        read_expect("rd_ch0", 7'h10, 32'h0001_0000, 2'b00);
        write_ok("wr_ctrl_all", 7'h00, 32'hFFFF_FFFF);
        read_expect("rd_ctrl_unused0", 7'h00, 32'h1, 2'b00);
        write_ok("wr_status", 7'h08, 32'h0000_0000);
        read_expect("rd_status_after_wr", 7'h08, 32'hD, 2'b00);

        // Error responses
        axi_write(7'h40, 32'h0002_0055, 4'hF, resp);
        check_value("wr_unmapped_resp", {30'd0, resp}, 32'd2);
        read_expect("rd_unmapped", 7'h40, 32'd0, 2'b10);
        read_expect("rd_hole_0c", 7'h0C, 32'd0, 2'b10);
        read_expect("rd_ch0_unchanged", 7'h10, 32'h0001_0000, 2'b00);
        read_expect("rd_status_unchanged", 7'h08, 32'hD, 2'b00);

        // Byte strobes
        write_ok("wr_ch0_full", 7'h10, 32'h0002_0040);
        axi_write(7'h10, 32'hFFFF_FFFF, 4'b0001, resp);
        check_value("wr_strb_resp", {30'd0, resp}, 32'd0);
        read_expect("rd_ch0_strb", 7'h10, 32'h0002_00FF, 2'b00);

        // PWM duty 64/256 at full rate
        apply_reset();
        write_ok("pwm_prescale", 7'h04, 32'd0);
        write_ok("pwm_ch0", 7'h10, 32'h0002_0040);
        write_ok("pwm_ctrl", 7'h00, 32'd1);
        prev = led_out[0];
        n = 0;
        @(negedge clk);
        while (!(!prev && led_out[0]) && n < 600) begin
            prev = led_out[0];
            @(negedge clk);
            n++;
        end
        check_value("pwm_rise_found", {31'd0, led_out[0]}, 32'd1);
        highs = 0; s63 = 0; s64 = 0;
        for (int i = 0; i < 256; i++) begin
            if (i == 63) s63 = int'(led_out[0]);
            if (i == 64) s64 = int'(led_out[0]);
            highs += int'(led_out[0]);
            @(negedge clk);
        end
        check_value("pwm_high_count", highs, 32'd64);
        check_value("pwm_last_high", s63, 32'd1);
        check_value("pwm_first_low", s64, 32'd0);
        check_value("pwm_period_rise", {31'd0, led_out[0]}, 32'd1);

        // Same-cycle read and write of PRESCALE returns the old value
        fork
            axi_write(7'h04, 32'd5, 4'hF, resp);
            axi_read(7'h04, rd, resp);
        join
        check_value("rw_collision_old", rd, 32'd0);
        read_expect("rw_collision_new", 7'h04, 32'd5, 2'b00);

        // Blink channel
        apply_reset();
        write_ok("blk_prescale", 7'h04, 32'd1);
        write_ok("blk_ch1", 7'h14, 32'h0003_0000);
        write_ok("blk_ctrl", 7'h00, 32'd1);
        read_expect("rd_ch1_mode3", 7'h14, 32'h0003_0000, 2'b00);
`ifdef LED_PWM_CTRL_BLINK_EN
        prev = led_out[1];
        n = 0;
        while (led_out[1] == prev && n < 600) begin @(negedge clk); n++; end
        prev = led_out[1];
        period = 0;
        while (led_out[1] == prev && period < 600) begin @(negedge clk); period++; end
        check_value("blink_half_period", period, 32'd256);
`else
        busy_seen = 1'b0;
        for (int i = 0; i < 600; i++) begin
            busy_seen |= led_out[1];
            @(negedge clk);
        end
        check_value("blink_disabled_off", {31'd0, busy_seen}, 32'd0);
        period = 0;
`endif

        // Write-response backpressure
        apply_reset();
        @(negedge clk);
        bus.S_AXI_AWADDR = 7'h04; bus.S_AXI_WDATA = 32'h12; bus.S_AXI_WSTRB = 4'hF;
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.S_AXI_AWREADY && n < 20);
        @(negedge clk);
        check_value("bp_bvalid_up", {31'd0, bus.S_AXI_BVALID}, 32'd1);
        bus.S_AXI_WDATA = 32'h55;
        busy_seen = 1'b0; bv_dropped = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            busy_seen  |= bus.S_AXI_AWREADY | bus.S_AXI_WREADY;
            bv_dropped |= ~bus.S_AXI_BVALID;
        end
        check_value("bp_no_accept", {31'd0, busy_seen}, 32'd0);
        check_value("bp_bvalid_held", {31'd0, bv_dropped}, 32'd0);
        check_value("bp_bresp", {30'd0, bus.S_AXI_BRESP}, 32'd0);
        bus.S_AXI_BREADY = 1'b1;
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        @(negedge clk);
        bus.S_AXI_BREADY = 1'b0;
        check_value("bp_bvalid_cleared", {31'd0, bus.S_AXI_BVALID}, 32'd0);
        read_expect("bp_prescale_first_only", 7'h04, 32'h12, 2'b00);

        // Reset in the middle of PWM with a read in flight
        write_ok("rst_prescale", 7'h04, 32'd0);
        write_ok("rst_ch0", 7'h10, 32'h0002_0040);
        write_ok("rst_ctrl", 7'h00, 32'd1);
        repeat (100) @(negedge clk);
        bus.S_AXI_ARADDR = 7'h00; bus.S_AXI_ARVALID = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        bus.S_AXI_ARVALID = 1'b0;
        @(negedge clk);
        check_value("rst_led_out", {28'd0, led_out}, 32'd0);
        check_value("rst_pwm_cnt", {24'd0, dut.r_pwm_cnt}, 32'd0);
        check_value("rst_presc_cnt", {16'd0, dut.r_presc_cnt}, 32'd0);
        rst = 1'b0;
        bv_dropped = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bv_dropped |= bus.S_AXI_RVALID | bus.S_AXI_ARREADY;
        end
        check_value("rst_read_abandoned", {31'd0, bv_dropped}, 32'd0);
        read_expect("rst_ctrl_cleared", 7'h00, 32'd0, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
